// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a small valid/ready input FIFO.
// Frames go out LSB-first: start, data, optional parity, stop bit(s),
// and queued words follow each other with no idle gap.
module uart_tx_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_ena,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    // Reject illegal configurations at elaboration
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_width
        $error("uart_tx_param: DATA_W must be 5..16");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_baud
        $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and pointers
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_d;
    logic              push;
    logic              pop;

    // FSM / datapath registers and their next values
    state_t            state;
    state_t            state_d;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_d;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_d;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_d;
    logic              par_bit;
    logic              par_d;
    logic              tx_d;
    logic              busy_d;
    logic              wrap;
    logic [DATA_W-1:0] head;
    logic              head_par;

    assign tx_ready   = (count < CNT_W'(FIFO_DEPTH));
    assign push       = tx_ena && tx_ready;
    assign fifo_count = count;
    assign head       = mem[rd_ptr];
    assign head_par   = (PARITY == 2) ? ~(^head) : (^head);
    assign wrap       = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy_d     = (state_d != S_IDLE) || (count_d != '0);

    // Occupancy update: simultaneous push and pop leave count unchanged
    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // FIFO data array write (no reset needed, guarded by count)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
        end
    end

    // Next-state, pop and line-level decisions for the frame sequencer
    always_comb begin
        state_d = state;
        baud_d  = wrap ? '0 : baud + BAUD_W'(1);
        bit_d   = bit_idx;
        shreg_d = shreg;
        par_d   = par_bit;
        tx_d    = tx;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    par_d   = head_par;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shreg[0];
                end
            end
            S_DATA: begin
                if (wrap) begin
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shreg_d = shreg >> 1;
                        bit_d   = bit_idx + BIT_W'(1);
                        tx_d    = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (count != '0) begin
                            pop     = 1'b1;
                            shreg_d = head;
                            par_d   = head_par;
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_idx + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_d;
            shreg   <= shreg_d;
            par_bit <= par_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
        end
    end

endmodule
